// File: rtl/vga_mem_pkg.sv
// Shared types for the VGA / CPU frame-memory arbiter: request owners,
// arbiter FSM states and the read-return tag carried alongside memory latency.
package vga_mem_pkg;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_VGA,
      OWN_CPU
   } owner_t;

   typedef enum logic {
      IDLE,
      RUN
   } arb_state_t;

   typedef struct packed {
      logic   valid;
      owner_t owner;
   } tag_t;

   localparam tag_t TAG_NONE = '{valid: 1'b0, owner: OWN_NONE};

endpackage

// File: rtl/mem_tag_pipe.sv
// Fixed-depth shift register of read-return tags; a tag pushed at one edge
// reaches the tail DEPTH-1 edges later. Synchronous active-low clear.
module mem_tag_pipe
   import vga_mem_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic clr_n,
   input  tag_t push,
   output tag_t tail
);

   tag_t stage [DEPTH];

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage[i] <= TAG_NONE;
         end
      end else begin
         stage[0] <= push;
         for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign tail = stage[DEPTH-1];

endmodule

// File: rtl/vga_mem_arbiter.sv
// Single-port frame-memory arbiter: VGA fetches have priority, the CPU is
// guaranteed progress after MAX_WAIT denials unless VGA marks its fetch urgent.
module vga_mem_arbiter
   import vga_mem_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MEM_LAT  = 1,
   parameter int MAX_WAIT = 4
) (
   input  logic              clock_25,
   input  logic              reset,
   input  logic              start,
   input  logic              vga_req,
   input  logic              vga_urgent,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic              vga_rvalid,
   output logic [DATA_W-1:0] vga_rdata,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [3:0]        cpu_wait
);

   localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

   arb_state_t state, state_nxt;
   logic       run_rules;
   logic       cpu_elig;
   logic       vga_win;
   logic       cpu_win;
   logic [3:0] wait_nxt;
   tag_t       tag_push;
   tag_t       tag_tail;

   always_ff @(posedge clock_25) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Handshake: the CPU holds cpu_req and its payload stable until it sees
   // cpu_gnt; the cycle cpu_gnt is high the request is not eligible again.
   always_comb begin
      state_nxt = state;
      run_rules = (state == RUN);
      if (state == IDLE && start) begin
         state_nxt = RUN;
         run_rules = 1'b1;
      end

      cpu_elig = cpu_req && !cpu_gnt;
      vga_win  = run_rules && vga_req && (vga_urgent || (cpu_wait < WAIT_MAX));
      cpu_win  = cpu_elig && !vga_win;

      wait_nxt = cpu_wait;
      if (!cpu_req || cpu_win) begin
         wait_nxt = 4'd0;
      end else if (cpu_elig) begin
         wait_nxt = (cpu_wait >= WAIT_MAX) ? WAIT_MAX : cpu_wait + 4'd1;
      end

      tag_push = TAG_NONE;
      if (vga_win) begin
         tag_push = '{valid: 1'b1, owner: OWN_VGA};
      end else if (cpu_win && !cpu_we) begin
         tag_push = '{valid: 1'b1, owner: OWN_CPU};
      end
   end

   always_ff @(posedge clock_25) begin
      if (!reset) begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_gnt   <= 1'b0;
         cpu_wait  <= 4'd0;
      end else begin
         mem_en   <= vga_win || cpu_win;
         mem_we   <= cpu_win && cpu_we;
         cpu_gnt  <= cpu_win;
         cpu_wait <= wait_nxt;
         if (vga_win) begin
            mem_addr <= vga_addr;
         end else if (cpu_win) begin
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
         end
      end
   end

   // One extra stage beyond MEM_LAT covers the registered issue cycle.
   mem_tag_pipe #(
      .DEPTH (MEM_LAT + 1)
   ) u_tag_pipe (
      .clk   (clock_25),
      .clr_n (reset),
      .push  (tag_push),
      .tail  (tag_tail)
   );

   always_ff @(posedge clock_25) begin
      if (!reset) begin
         vga_rvalid <= 1'b0;
         vga_rdata  <= '0;
         cpu_rvalid <= 1'b0;
         cpu_rdata  <= '0;
      end else begin
         vga_rvalid <= tag_tail.valid && (tag_tail.owner == OWN_VGA);
         cpu_rvalid <= tag_tail.valid && (tag_tail.owner == OWN_CPU);
         if (tag_tail.valid && tag_tail.owner == OWN_VGA) begin
            vga_rdata <= mem_rdata;
         end
         if (tag_tail.valid && tag_tail.owner == OWN_CPU) begin
            cpu_rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Bench for vga_mem_arbiter: directed vector table, hand sequences and random
// traffic, all checked against a timestamped reference model of the arbiter.
module tb_vga_mem_arbiter;

   localparam int ADDR_W   = 32;
   localparam int DATA_W   = 32;
   localparam int MEM_LAT  = 1;
   localparam int MAX_WAIT = 4;

   logic              clock_25;
   logic              reset;
   logic              start;
   logic              vga_req;
   logic              vga_urgent;
   logic [ADDR_W-1:0] vga_addr;
   logic              vga_rvalid;
   logic [DATA_W-1:0] vga_rdata;
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_gnt;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic [3:0]        cpu_wait;

   vga_mem_arbiter #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .MEM_LAT  (MEM_LAT),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clock_25   (clock_25),
      .reset      (reset),
      .start      (start),
      .vga_req    (vga_req),
      .vga_urgent (vga_urgent),
      .vga_addr   (vga_addr),
      .vga_rvalid (vga_rvalid),
      .vga_rdata  (vga_rdata),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .cpu_wait   (cpu_wait)
   );

   // ---------------- clock / reset ----------------
   initial clock_25 = 1'b0;
   always #20 clock_25 = ~clock_25;

   function automatic logic [31:0] init_word(input int unsigned a);
      logic [7:0] b;
      b = 8'(a);
      return {b, ~b, 8'h5A, b ^ 8'hC3};
   endfunction

   // ---------------- behavioural memory (MEM_LAT read latency) ----------------
   logic [DATA_W-1:0] mem_arr [256];
   logic [DATA_W-1:0] rd_pipe [MEM_LAT];
   logic              mem_ready = 1'b0;

   always @(posedge clock_25) begin
      if (!mem_ready) begin
         for (int i = 0; i < 256; i++) mem_arr[i] <= init_word(i);
         mem_ready <= 1'b1;
      end else if (mem_en) begin
         if (mem_we) mem_arr[mem_addr[7:0]] <= mem_wdata;
         else        rd_pipe[0] <= mem_arr[mem_addr[7:0]];
      end
      for (int k = 1; k < MEM_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
   end
   assign mem_rdata = rd_pipe[MEM_LAT-1];

   // ---------------- reference model / scoreboard ----------------
   int unsigned       n_tests = 0;
   int unsigned       n_fail  = 0;
   int unsigned       cyc     = 0;
   int unsigned       n_en, n_vrv, n_crv;
   logic [DATA_W-1:0] model_mem [256];
   logic [DATA_W-1:0] exp_q [$];
   int unsigned       due_q [$];
   bit                own_cpu_q [$];
   bit                m_run, m_gnt;
   int                m_wait;
   bit                exp_en, exp_we, exp_gnt;
   logic [ADDR_W-1:0] exp_addr;
   logic [DATA_W-1:0] exp_wdata;
   logic [DATA_W-1:0] last_vga, last_cpu;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_read(input logic [ADDR_W-1:0] a, input bit is_cpu);
      exp_q.push_back(model_mem[a[7:0]]);
      due_q.push_back(cyc + 1 + MEM_LAT);
      own_cpu_q.push_back(is_cpu);
   endtask

   // Called right after each rising edge with the inputs sampled at that edge.
   task automatic model_update();
      bit run_r, elig, vw, cw;
      cyc++;
      if (!reset) begin
         m_run = 0; m_wait = 0; m_gnt = 0;
         exp_en = 0; exp_we = 0; exp_gnt = 0;
         exp_q.delete(); due_q.delete(); own_cpu_q.delete();
         last_vga = '0; last_cpu = '0;
         return;
      end
      run_r = m_run || start;
      elig  = cpu_req && !m_gnt;
      vw    = run_r && vga_req && (vga_urgent || m_wait < MAX_WAIT);
      cw    = !vw && elig;
      exp_en  = vw || cw;
      exp_we  = cw && cpu_we;
      exp_gnt = cw;
      if (vw) begin
         exp_addr = vga_addr;
         push_read(vga_addr, 1'b0);
      end else if (cw) begin
         exp_addr = cpu_addr;
         if (cpu_we) begin
            exp_wdata = cpu_wdata;
            model_mem[cpu_addr[7:0]] = cpu_wdata;
         end else begin
            push_read(cpu_addr, 1'b1);
         end
      end
      if (!cpu_req || cw) m_wait = 0;
      else if (elig)      m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
      m_gnt = cw;
      m_run = run_r;
   endtask

   task automatic model_check();
      bit ev, ec;
      ev = 0; ec = 0;
      chk("mem_en", mem_en, exp_en);
      if (exp_en) begin
         chk("mem_we", mem_we, exp_we);
         chk("mem_addr", mem_addr, exp_addr);
         if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
      end
      chk("cpu_gnt", cpu_gnt, exp_gnt);
      chk("cpu_wait", cpu_wait, 64'(m_wait));
      if (due_q.size() > 0 && due_q[0] == cyc) begin
         if (own_cpu_q[0]) begin ec = 1; last_cpu = exp_q[0]; end
         else              begin ev = 1; last_vga = exp_q[0]; end
         void'(exp_q.pop_front());
         void'(due_q.pop_front());
         void'(own_cpu_q.pop_front());
      end
      chk("vga_rvalid", vga_rvalid, ev);
      chk("cpu_rvalid", cpu_rvalid, ec);
      chk("vga_rdata", vga_rdata, last_vga);
      chk("cpu_rdata", cpu_rdata, last_cpu);
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clock_25);
      model_update();
      @(negedge clock_25);
      model_check();
      if (mem_en)     n_en++;
      if (vga_rvalid) n_vrv++;
      if (cpu_rvalid) n_crv++;
   endtask

   task automatic drive(input logic st, input logic vr, input logic vu, input logic [7:0] va,
                        input logic cr, input logic cw, input logic [7:0] ca,
                        input logic [31:0] wd);
      start = st; vga_req = vr; vga_urgent = vu; vga_addr = {24'h0, va};
      cpu_req = cr; cpu_we = cw; cpu_addr = {24'h0, ca}; cpu_wdata = wd;
   endtask

   task automatic idle(input int n);
      drive(0, 0, 0, 8'h00, 0, 0, 8'h00, 32'h0);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".mem_en"}, mem_en, 0);
      chk({tag, ".mem_we"}, mem_we, 0);
      chk({tag, ".mem_addr"}, mem_addr, 0);
      chk({tag, ".mem_wdata"}, mem_wdata, 0);
      chk({tag, ".cpu_gnt"}, cpu_gnt, 0);
      chk({tag, ".rvalids"}, {vga_rvalid, cpu_rvalid}, 0);
      chk({tag, ".vga_rdata"}, vga_rdata, 0);
      chk({tag, ".cpu_rdata"}, cpu_rdata, 0);
      chk({tag, ".cpu_wait"}, cpu_wait, 0);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic       st, vr, vu;
      logic [7:0] va;
      logic       cr, cw;
      logic [7:0] ca;
      logic [31:0] wd;
      logic       e_en, e_we;
      logic [7:0] e_addr;
      logic       e_gnt;
      logic [3:0] e_wait;
   } vec_t;

   localparam int NV = 23;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic st, vr, vu, input logic [7:0] va,
                               input logic cr, cw, input logic [7:0] ca, input logic [31:0] wd,
                               input logic e_en, e_we, input logic [7:0] e_addr,
                               input logic e_gnt, input logic [3:0] e_wait);
      vec_t v;
      v.st = st; v.vr = vr; v.vu = vu; v.va = va; v.cr = cr; v.cw = cw; v.ca = ca; v.wd = wd;
      v.e_en = e_en; v.e_we = e_we; v.e_addr = e_addr; v.e_gnt = e_gnt; v.e_wait = e_wait;
      return v;
   endfunction

   initial begin
      //           st vr vu va     cr cw ca     wdata         en we addr   gnt wait
      vecs[0]  = mk(0, 1, 0, 8'h10, 0, 0, 8'h00, 32'h0,        0, 0, 8'h00, 0, 0); // IDLE ignores VGA
      vecs[1]  = mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 32'h0,        0, 0, 8'h00, 0, 0);
      vecs[2]  = mk(0, 1, 0, 8'h10, 0, 0, 8'h00, 32'h0,        1, 0, 8'h10, 0, 0);
      vecs[3]  = mk(0, 1, 0, 8'h20, 1, 0, 8'h40, 32'h0,        1, 0, 8'h20, 0, 1); // starvation
      vecs[4]  = mk(0, 1, 0, 8'h21, 1, 0, 8'h40, 32'h0,        1, 0, 8'h21, 0, 2);
      vecs[5]  = mk(0, 1, 0, 8'h22, 1, 0, 8'h40, 32'h0,        1, 0, 8'h22, 0, 3);
      vecs[6]  = mk(0, 1, 0, 8'h23, 1, 0, 8'h40, 32'h0,        1, 0, 8'h23, 0, 4);
      vecs[7]  = mk(0, 1, 0, 8'h24, 1, 0, 8'h40, 32'h0,        1, 0, 8'h40, 1, 0);
      vecs[8]  = mk(0, 1, 0, 8'h25, 1, 0, 8'h40, 32'h0,        1, 0, 8'h25, 0, 0);
      vecs[9]  = mk(0, 1, 0, 8'h26, 0, 0, 8'h00, 32'h0,        1, 0, 8'h26, 0, 0);
      vecs[10] = mk(0, 1, 1, 8'h30, 1, 0, 8'h44, 32'h0,        1, 0, 8'h30, 0, 1); // urgent blocks
      vecs[11] = mk(0, 1, 1, 8'h31, 1, 0, 8'h44, 32'h0,        1, 0, 8'h31, 0, 2);
      vecs[12] = mk(0, 1, 1, 8'h32, 1, 0, 8'h44, 32'h0,        1, 0, 8'h32, 0, 3);
      vecs[13] = mk(0, 1, 1, 8'h33, 1, 0, 8'h44, 32'h0,        1, 0, 8'h33, 0, 4);
      vecs[14] = mk(0, 1, 1, 8'h34, 1, 0, 8'h44, 32'h0,        1, 0, 8'h34, 0, 4);
      vecs[15] = mk(0, 1, 1, 8'h35, 1, 0, 8'h44, 32'h0,        1, 0, 8'h35, 0, 4);
      vecs[16] = mk(0, 0, 0, 8'h00, 1, 0, 8'h44, 32'h0,        1, 0, 8'h44, 1, 0);
      vecs[17] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 32'h0,        0, 0, 8'h00, 0, 0);
      vecs[18] = mk(0, 0, 0, 8'h00, 1, 1, 8'h50, 32'hDEADBEEF, 1, 1, 8'h50, 1, 0); // no double issue
      vecs[19] = mk(0, 0, 0, 8'h00, 1, 1, 8'h50, 32'hDEADBEEF, 0, 0, 8'h00, 0, 0);
      vecs[20] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 32'h0,        0, 0, 8'h00, 0, 0);
      vecs[21] = mk(0, 0, 0, 8'h00, 1, 0, 8'h50, 32'h0,        1, 0, 8'h50, 1, 0);
      vecs[22] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 32'h0,        0, 0, 8'h00, 0, 0);
   end

   // ---------------- test sequence ----------------
   initial begin
      for (int i = 0; i < 256; i++) model_mem[i] = init_word(i);
      last_vga = '0; last_cpu = '0;
      reset = 1'b0;
      drive(0, 0, 0, 8'h00, 0, 0, 8'h00, 32'h0);
      for (int i = 0; i < 3; i++) step();
      chk_all_zero("reset");
      reset = 1'b1;

      // directed table
      n_en = 0; n_vrv = 0; n_crv = 0;
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].st, vecs[i].vr, vecs[i].vu, vecs[i].va,
               vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].wd);
         step();
         chk($sformatf("vec%0d.mem_en", i), mem_en, vecs[i].e_en);
         if (vecs[i].e_en) begin
            chk($sformatf("vec%0d.mem_we", i), mem_we, vecs[i].e_we);
            chk($sformatf("vec%0d.mem_addr", i), mem_addr, {24'h0, vecs[i].e_addr});
         end
         chk($sformatf("vec%0d.cpu_gnt", i), cpu_gnt, vecs[i].e_gnt);
         chk($sformatf("vec%0d.cpu_wait", i), cpu_wait, vecs[i].e_wait);
      end
      idle(4);
      chk("table.cpu_rvalid_count", n_crv, 3);

      // back-to-back VGA fetches
      n_en = 0; n_vrv = 0;
      for (int i = 0; i < 8; i++) begin
         drive(0, 1, 0, 8'(i), 0, 0, 8'h00, 32'h0);
         step();
      end
      idle(4);
      chk("b2b.mem_en_count", n_en, 8);
      chk("b2b.vga_rvalid_count", n_vrv, 8);

      // reset while a CPU read is in flight
      drive(0, 0, 0, 8'h00, 1, 0, 8'h40, 32'h0);
      step();
      chk("rstmid.gnt", cpu_gnt, 1);
      drive(0, 0, 0, 8'h00, 0, 0, 8'h00, 32'h0);
      reset = 1'b0;
      step();
      chk_all_zero("rstmid");
      reset = 1'b1;
      n_crv = 0;
      idle(5);
      chk("rstmid.no_cpu_rvalid", n_crv, 0);

      // VGA request sampled on the same edge as start is served
      drive(1, 1, 0, 8'h33, 0, 0, 8'h00, 32'h0);
      step();
      chk("start_same_edge.mem_en", mem_en, 1);
      chk("start_same_edge.mem_addr", mem_addr, 32'h33);
      idle(4);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         start      = ($urandom_range(0, 63) == 0);
         vga_req    = ($urandom_range(0, 2) != 0);
         vga_urgent = ($urandom_range(0, 3) == 0);
         vga_addr   = {24'h0, 8'($urandom_range(0, 255))};
         if (cpu_req && cpu_gnt) begin
            cpu_req = 1'b0;
         end else if (!cpu_req && $urandom_range(0, 2) == 0) begin
            cpu_req   = 1'b1;
            cpu_we    = ($urandom_range(0, 2) == 0);
            cpu_addr  = {24'h0, 8'($urandom_range(0, 255))};
            cpu_wdata = $urandom;
         end
         reset = ($urandom_range(0, 299) != 0);
         if (!reset) cpu_req = 1'b0;
         step();
      end
      reset = 1'b1;
      idle(6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
